// File: rtl/maze_loader_pkg.sv
// Shared constants for the maze loader, its address generator and the map memory
// instantiation sites.
package maze_loader_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int unsigned MAZE_WIDTH  = 16;
   localparam int unsigned MAZE_HEIGHT = 16;
   localparam int unsigned MAZE_ADDR_W = 4;
   localparam int unsigned MAZE_ADDR_H = 4;

endpackage

// File: rtl/maze_loader_if.sv
// Cell stream, map-memory write port and status bundle of the maze loader.
interface maze_loader_if
   import maze_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = MAZE_ADDR_W,
   parameter int unsigned ADDR_H = MAZE_ADDR_H,
   parameter int unsigned CNT_W  = ADDR_W + ADDR_H + 1
);

   logic              start;
   logic              abort;
   logic              in_valid;
   logic              in_data;
   logic              in_ready;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr_x;
   logic [ADDR_H-1:0] mem_addr_y;
   logic              mem_data;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  ones_count;

   modport master (
      output start, abort, in_valid, in_data,
      input  in_ready, mem_wr, mem_addr_x, mem_addr_y, mem_data, busy, done, ones_count
   );

   modport slave (
      input  start, abort, in_valid, in_data,
      output in_ready, mem_wr, mem_addr_x, mem_addr_y, mem_data, busy, done, ones_count
   );

endinterface

// File: rtl/maze_addr_gen.sv
// Row-major 2-D cell address counter (x fastest) with clear, advance and a
// last-cell flag; wraps x at WIDTH rather than at the address width.
module maze_addr_gen
   import maze_loader_pkg::*;
#(
   parameter int unsigned WIDTH  = MAZE_WIDTH,
   parameter int unsigned HEIGHT = MAZE_HEIGHT,
   parameter int unsigned ADDR_W = MAZE_ADDR_W,
   parameter int unsigned ADDR_H = MAZE_ADDR_H
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_adv,
   output logic [ADDR_W-1:0] o_x,
   output logic [ADDR_H-1:0] o_y,
   output logic              o_last
);

   localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(WIDTH - 1);
   localparam logic [ADDR_H-1:0] Y_LAST = ADDR_H'(HEIGHT - 1);

   logic [ADDR_W-1:0] r_x;
   logic [ADDR_H-1:0] r_y;
   logic              w_x_end;
   logic              w_last;

   assign w_x_end = (r_x == X_LAST);
   assign w_last  = w_x_end && (r_y == Y_LAST);

   // Advancing from the last cell holds there; y never runs past HEIGHT-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_clr) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_adv && !w_last) begin
         if (w_x_end) begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
         end else begin
            r_x <= r_x + 1'b1;
         end
      end
   end

   assign o_x    = r_x;
   assign o_y    = r_y;
   assign o_last = w_last;

endmodule

// File: rtl/maze_loader.sv
// Streams a row-major maze bitmap into the 1-bit map memory, one cell per
// handshake, and counts the blocked cells written.
module maze_loader
   import maze_loader_pkg::*;
#(
   parameter int unsigned WIDTH  = MAZE_WIDTH,
   parameter int unsigned HEIGHT = MAZE_HEIGHT,
   parameter int unsigned ADDR_W = MAZE_ADDR_W,
   parameter int unsigned ADDR_H = MAZE_ADDR_H,
   parameter int unsigned CNT_W  = ADDR_W + ADDR_H + 1
) (
   input  logic          clk,
   input  logic          rst,
   maze_loader_if.slave  io_bus
);

   state_e            r_state;
   state_e            w_state_d;
   logic [CNT_W-1:0]  r_ones;
   logic              w_ready;
   logic              w_xfer;
   logic              w_clr;
   logic              w_last;
   logic [ADDR_W-1:0] w_x;
   logic [ADDR_H-1:0] w_y;

   assign w_ready = (r_state == S_LOAD) && !io_bus.abort;
   assign w_xfer  = w_ready && io_bus.in_valid;
   assign w_clr   = (r_state == S_IDLE) && io_bus.start;

   maze_addr_gen #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .ADDR_W (ADDR_W),
      .ADDR_H (ADDR_H)
   ) u_addr_gen (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_adv  (w_xfer),
      .o_x    (w_x),
      .o_y    (w_y),
      .o_last (w_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (io_bus.start) w_state_d = S_LOAD;
         end
         S_LOAD: begin
            if (io_bus.abort) begin
               w_state_d = S_IDLE;
            end else if (w_xfer && w_last) begin
               w_state_d = S_DONE;
            end
         end
         S_DONE:  w_state_d = S_IDLE;
         default: w_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ones <= '0;
      end else if (w_clr) begin
         r_ones <= '0;
      end else if (w_xfer && io_bus.in_data) begin
         r_ones <= r_ones + 1'b1;
      end
   end

   // Write data is gated so the port reads 0 whenever nothing is being written.
   assign io_bus.in_ready   = w_ready;
   assign io_bus.mem_wr     = w_xfer;
   assign io_bus.mem_addr_x = w_x;
   assign io_bus.mem_addr_y = w_y;
   assign io_bus.mem_data   = w_xfer && io_bus.in_data;
   assign io_bus.busy       = (r_state == S_LOAD);
   assign io_bus.done       = (r_state == S_DONE);
   assign io_bus.ones_count = r_ones;

endmodule
